loba_div_16_4: RTL and testbench
================================

Name: loba_div_16_4

Overview:
- Sequential approximate unsigned divider, the inverse-direction companion to the LOBA approximate multipliers in the arithmetic library.
- Computes Q ≈ A / B using leading-one truncation.
  - The divisor is reduced to its K most significant bits starting at its leading one.
  - The dividend is divided exactly by that K-bit segment, one restoring step per cycle.
  - The result is then shifted back by the truncation amount.
- Sits beside the multipliers in error-characterisation benches and in accelerator datapaths.
- Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16: operand and quotient width (unsigned).
- K, 4: retained divisor segment width; K ≤ WIDTH.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A, B valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- out_valid  output  1  Q and div_by_zero valid.
- out_ready  input  1  consumer accepts result.
- Q  output  WIDTH  approximate quotient.
- div_by_zero  output  1  set with the result when B was 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Returns to IDLE from any state; an in-flight operation is discarded.
  - out_valid=0, Q=0, div_by_zero=0, in_ready=1 on the following cycle.
- States: IDLE, NORM, DIV, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 registers A and B, then goes to NORM.
- NORM:
  - Leading-one detect on B gives position kb (0..WIDTH-1).
  - If B==0: Q=all ones, div_by_zero=1, go to DONE.
  - Otherwise:
    - s = kb-(K-1) if kb ≥ K-1, else 0.
    - Bh = B>>s, K bits; its MSB is set whenever s>0.
    - Remainder R=0, quotient register = A, step counter = WIDTH-1; go to DIV.
- DIV: WIDTH cycles of restoring division of A by Bh, MSB first. Each cycle:
  - R' = {R, next dividend bit}.
  - If R' ≥ Bh: R = R'-Bh and the quotient bit is 1; else R = R' and the quotient bit is 0.
  - R needs K+1 bits.
  - After counter 0, go to SHIFT.
- SHIFT:
  - Q = (A / Bh) >> s (logical right shift, truncating), go to DONE.
  - When s=0 the result is exact floor(A/B).
- DONE:
  - out_valid=1, in_ready=0.
  - Q and div_by_zero are held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE; out_valid drops on the next cycle.
- Latency, counted from the accepting edge:
  - B≠0: out_valid asserts WIDTH+3 cycles later (19 at defaults).
  - B=0: out_valid asserts 2 cycles later.
- Throughput: one operation in flight; in_ready=0 in NORM through DONE. A new operand cannot be accepted in the same cycle a result is consumed.
- out_ready is ignored outside DONE.
- A=0 gives Q=0, div_by_zero=0.
- Q and div_by_zero keep their last values while in IDLE; they are meaningful only when out_valid=1.

Decomposition:
- Shared package loba_pkg holds:
  - the state enum (IDLE, NORM, DIV, SHIFT, DONE);
  - a clog2-based width constant for kb and s;
  - the default WIDTH and K constants, reused by the LOBA multipliers.
- One sub-module, loba_lod:
  - parameterised leading-one detector;
  - input WIDTH bits; outputs position (clog2(WIDTH) bits) and a zero flag;
  - purely combinational, also usable by the multiplier split logic.

Test Plan:
- A=1000, B=10 (kb=3, s=0, Bh=10) -> Q=100, div_by_zero=0; out_valid exactly 19 cycles after acceptance.
- A=60000, B=300 (kb=8, s=5, Bh=9) -> 60000/9=6666, Q=6666>>5=208 (exact 200).
- A=0xFFFF, B=1 -> Q=0xFFFF; A=5, B=0xFFFF (s=12, Bh=15) -> Q=0; A=0, B=7 -> Q=0.
- B=0, A=1234 -> Q=0xFFFF, div_by_zero=1, out_valid 2 cycles after acceptance.
- Backpressure on A=1000, B=10:
  - out_ready held low 5 cycles in DONE -> Q=100 stable, out_valid=1, in_ready=0 throughout.
  - in_valid pulses meanwhile are not accepted.
  - out_ready=1 -> IDLE next cycle.
- Reset in DIV at step 8 -> next cycle IDLE, out_valid=0, Q=0, in_ready=1.
  - The next operation (A=81, B=9) returns Q=9 with normal latency.

Source files
------------

// File: rtl/loba_pkg.sv
// Shared LOBA arithmetic definitions: FSM states and default
// operand/segment widths used by the dividers and multipliers.
package loba_pkg;

  localparam int LOBA_WIDTH = 16;
  localparam int LOBA_K     = 4;

  // Width of a bit position (leading-one index, shift amount)
  localparam int LOBA_PW = $clog2(LOBA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_DIV,
    ST_SHIFT,
    ST_DONE
  } loba_state_t;

endpackage

// File: rtl/loba_lod.sv
// Leading-one detector: position of the highest set bit of val.
// Ports: val (WIDTH) in; pos ($clog2(WIDTH)) out; zero out (val==0).
module loba_lod #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         val,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     zero
);

  localparam int PW = $clog2(WIDTH);

  // Ascending scan so the highest set bit wins
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (val[i]) pos = PW'(i);
    end
  end

  assign zero = ~|val;

endmodule

// File: rtl/loba_div_16_4.sv
// Sequential LOBA approximate divider: Q ~= A / B using a K-bit
// divisor segment taken from B's leading one, then shifted back.
// Ports: clk, rst (sync, high); in_valid/in_ready, A, B in;
// out_valid/out_ready, Q, div_by_zero out.
module loba_div_16_4
  import loba_pkg::*;
#(
  parameter int WIDTH = LOBA_WIDTH,
  parameter int K     = LOBA_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             div_by_zero
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] KM1  = PW'(K - 1);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

  loba_state_t state, state_nx;

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] qr_q;
  logic [K-1:0]     bh_q;
  logic [K-1:0]     rem_q;
  logic [PW-1:0]    s_q;
  logic [PW-1:0]    cnt_q;

  logic [PW-1:0]    kb;
  logic             b_zero;
  logic [PW-1:0]    s_nx;
  logic [WIDTH-1:0] b_sh;
  logic [K-1:0]     bh_nx;

  logic [K:0]       rp;
  logic [K:0]       diff;
  logic             ge;

  loba_lod #(
    .WIDTH(WIDTH)
  ) u_lod (
    .val (b_q),
    .pos (kb),
    .zero(b_zero)
  );

  // Truncation amount keeps the leading one as segment MSB
  assign s_nx  = (kb >= KM1) ? (kb - KM1) : '0;
  assign b_sh  = b_q >> s_nx;
  assign bh_nx = b_sh[K-1:0];

  // One restoring step; qr_q shifts dividend bits out at
  // the top and quotient bits in at the bottom
  assign rp   = {rem_q, qr_q[WIDTH-1]};
  assign ge   = rp >= {1'b0, bh_q};
  assign diff = rp - {1'b0, bh_q};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (in_valid) state_nx = ST_NORM;
      ST_NORM:  state_nx = b_zero ? ST_DONE : ST_DIV;
      ST_DIV:   if (cnt_q == '0) state_nx = ST_SHIFT;
      ST_SHIFT: state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q         <= '0;
      qr_q        <= '0;
      bh_q        <= '0;
      rem_q       <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      Q           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            qr_q <= A;
            b_q  <= B;
          end
        end
        ST_NORM: begin
          if (b_zero) begin
            Q           <= '1;
            div_by_zero <= 1'b1;
          end else begin
            s_q         <= s_nx;
            bh_q        <= bh_nx;
            rem_q       <= '0;
            cnt_q       <= LAST;
            div_by_zero <= 1'b0;
          end
        end
        ST_DIV: begin
          rem_q <= ge ? diff[K-1:0] : rp[K-1:0];
          qr_q  <= {qr_q[WIDTH-2:0], ge};
          cnt_q <= cnt_q - 1'b1;
        end
        ST_SHIFT: begin
          Q <= qr_q >> s_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loba_div_16_4.sv
// Scoreboard bench for loba_div_16_4: directed vectors, expected
// results queued at issue, checked by an independent monitor.
module tb_loba_div_16_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic        dbz;
    int          lat;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   first = 1'b1;

  loba_div_16_4 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (Q),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: peek while out_valid, pop on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        if (first) begin
          chk("latency", cyc - exp_q[0].c, exp_q[0].lat);
          first = 1'b0;
        end
        chk("q", int'(Q), int'(exp_q[0].q));
        chk("dbz", int'(div_by_zero), int'(exp_q[0].dbz));
        chk("in_ready_busy", int'(in_ready), 0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          first = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] q,
                       input logic        dbz);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    A = a;
    B = b;
    e.q   = q;
    e.dbz = dbz;
    e.lat = (b == 16'd0) ? 2 : 19;
    e.c   = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_q", int'(Q), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    issue(16'd1000, 16'd10, 16'd100, 1'b0);
    issue(16'd60000, 16'd300, 16'd208, 1'b0);
    issue(16'hFFFF, 16'd1, 16'hFFFF, 1'b0);
    issue(16'd5, 16'hFFFF, 16'd0, 1'b0);
    issue(16'd0, 16'd7, 16'd0, 1'b0);
    issue(16'd1234, 16'd0, 16'hFFFF, 1'b1);
    issue(16'd100, 16'd7, 16'd14, 1'b0);
    issue(16'd50000, 16'd1000, 16'd52, 1'b0);
    issue(16'hFFFF, 16'h8000, 16'd1, 1'b0);
    drain();

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    issue(16'd1000, 16'd10, 16'd100, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      A = 16'd7;
      B = 16'd1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_valid", int'(out_valid), 0);
    chk("bp_idle_ready", int'(in_ready), 1);
    repeat (25) @(posedge clk);
    #1;

    // Reset while dividing, at step counter 8
    wait_ready();
    in_valid = 1'b1;
    A = 16'd60000;
    B = 16'd300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_q", int'(Q), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    issue(16'd81, 16'd9, 16'd9, 1'b0);
    drain();
    repeat (25) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
